// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one repeated-addition multiplier datapath among NREQ requesters.
// Optional abort-on-timeout behaviour is compiled in with `define MUL_TIMEOUT_EN.
module mul_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 16,
    parameter int TO_LIMIT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_bus,
    input  logic [NREQ*W-1:0] b_bus,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [2*W-1:0]    result,
    output logic              result_valid,
    output logic              busy,
    output logic              err,
    output logic [W-1:0]      dp_a,
    output logic [W-1:0]      dp_b,
    output logic              lda,
    output logic              ldb,
    output logic              ldp,
    output logic              clrp,
    output logic              decb,
    input  logic              eqz,
    input  logic [2*W-1:0]    p_in
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_LDA, S_LDB, S_ACC, S_DONE} state_t;

    // Handshake: req is held with stable operands until the one-cycle ack;
    // gnt marks ownership of the datapath from ARB exit to DONE exit.
    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TO_LIMIT + 1);
    logic [CW-1:0] to_cnt;
    logic          to_hit;
    logic          err_q;
    assign to_hit = (to_cnt == CW'(TO_LIMIT - 1));
    assign err    = err_q;
`else
    assign err = 1'b0;
`endif

    // Scan downwards so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        int j;
        j       = 0;
        arb_idx = '0;
        arb_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) begin
                arb_idx = IW'(j);
                arb_any = 1'b1;
            end
        end
    end

    always_comb begin
        dp_a = '0;
        dp_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                dp_a = a_bus[i*W +: W];
                dp_b = b_bus[i*W +: W];
            end
        end
    end

    assign lda          = (state == S_LDA);
    assign ldb          = (state == S_LDB);
    assign clrp         = (state == S_LDB);
    assign ldp          = (state == S_ACC) && !eqz;
    assign decb         = (state == S_ACC) && !eqz;
    assign result_valid = |ack;
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gnt     <= '0;
            ack     <= '0;
            result  <= '0;
            ptr     <= '0;
            win_idx <= '0;
`ifdef MUL_TIMEOUT_EN
            to_cnt  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (|req) state <= S_ARB;
                S_ARB: begin
                    if (arb_any) begin
                        gnt     <= NREQ'(1) << arb_idx;
                        win_idx <= arb_idx;
                        state   <= S_LDA;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LDA: state <= S_LDB;
                S_LDB: begin
                    state <= S_ACC;
`ifdef MUL_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                S_ACC: begin
                    if (eqz) begin
                        result <= p_in;
                        ack    <= gnt;
                        state  <= S_DONE;
`ifdef MUL_TIMEOUT_EN
                    end else if (to_hit) begin
                        result <= '0;
                        ack    <= gnt;
                        err_q  <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    ack   <= '0;
                    gnt   <= '0;
                    ptr   <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state <= S_IDLE;
`ifdef MUL_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
